// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or FWFT read, threshold flags,
// occupancy count, sticky error flags and synchronous flush.
module sync_fifo #(
  parameter int W        = 8,
  parameter int DEPTH    = 8,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wen,
  input  logic [W-1:0]             din,
  input  logic                     ren,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [W-1:0]  dout_q, dout_d;
  logic [W-1:0]  head;
  logic          wr_acc, rd_acc;
  logic          wr_rej, rd_rej;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  // FWFT presents the head directly; standard mode uses the read register.
  assign dout = (FWFT != 0) ? (empty ? '0 : head) : dout_q;

  always_comb begin
    wr_acc   = wen && !full  && !flush;
    rd_acc   = ren && !empty && !flush;
    wr_rej   = wen && full   && !flush;
    rd_rej   = ren && empty  && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    ovf_d    = clr_err ? 1'b0 : ovf_q;
    unf_d    = clr_err ? 1'b0 : unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + CW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + CW'(1);
    end
    if (rd_acc) dout_d = head;
    if (wr_rej) ovf_d = 1'b1;
    if (rd_rej) unf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised bench for sync_fifo: standard and FWFT instances share
// stimulus and are checked against a queue-based reference model.
module tb_sync_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         wen, ren, flush, clr_err;
  logic [W-1:0] din;

  logic [W-1:0] dout_s, dout_f;
  logic         full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
  logic         full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [3:0]   cnt_s, cnt_f;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] q[$];
  logic         m_ovf, m_unf;
  logic [W-1:0] m_dout;

  always #5 clk = ~clk;

  sync_fifo #(.W(W), .DEPTH(DEPTH), .FWFT(0),
              .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
    .clk(clk), .reset(reset), .wen(wen), .din(din),
    .ren(ren), .flush(flush), .clr_err(clr_err),
    .dout(dout_s), .full(full_s), .empty(empty_s),
    .almost_full(af_s), .almost_empty(ae_s),
    .count(cnt_s), .overflow(ovf_s), .underflow(unf_s)
  );

  sync_fifo #(.W(W), .DEPTH(DEPTH), .FWFT(1),
              .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
    .clk(clk), .reset(reset), .wen(wen), .din(din),
    .ren(ren), .flush(flush), .clr_err(clr_err),
    .dout(dout_f), .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f),
    .count(cnt_f), .overflow(ovf_f), .underflow(unf_f)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic check_all();
    int n;
    logic [6:0] st;
    n  = q.size();
    st = {n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_unf, 1'b0};
    chk("count",     32'(cnt_s),     32'(n));
    chk("full",      32'(full_s),    32'(n == DEPTH));
    chk("empty",     32'(empty_s),   32'(n == 0));
    chk("alm_full",  32'(af_s),      32'(n >= AF));
    chk("alm_empty", 32'(ae_s),      32'(n <= AE));
    chk("overflow",  32'(ovf_s),     32'(m_ovf));
    chk("underflow", 32'(unf_s),     32'(m_unf));
    chk("dout_std",  32'(dout_s),    32'(m_dout));
    chk("dout_fwft", 32'(dout_f),    32'(n == 0 ? 8'h00 : q[0]));
    chk("cnt_fwft",  32'(cnt_f),     32'(n));
    chk("st_fwft",
        32'({full_f, empty_f, af_f, ae_f, ovf_f, unf_f, 1'b0}),
        32'(st));
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dout = '0;
  endtask

  task automatic cyc(input logic w, input logic [W-1:0] d,
                     input logic r, input logic f, input logic c);
    int n;
    wen = w; din = d; ren = r; flush = f; clr_err = c;
    @(posedge clk);
    n = q.size();
    if (c) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (f) begin
      q.delete();
    end else begin
      if (w && n == DEPTH) m_ovf = 1'b1;
      if (r && n == 0)     m_unf = 1'b1;
      if (r && n > 0)      m_dout = q.pop_front();
      if (w && n < DEPTH)  q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1;
    wen = 0; ren = 0; flush = 0; clr_err = 0; din = '0;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1 reset = 1'b0;

    // Fill to full.
    for (int i = 0; i < 8; i++) cyc(1, 8'(8'h10 + i), 0, 0, 0);
    // Overflow, then drain in order.
    cyc(1, 8'hAA, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0, 0);
    chk("drain_last", 32'(dout_s), 32'h17);

    // Streaming wrap-around at count 3.
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h30 + i), 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 8'(8'h40 + i), 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0, 0);
    chk("wrap_tail", 32'(dout_s), 32'h53);

    // Underflow and clear; error wins over clear.
    cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    chk("unf_set_wins", 32'(unf_s), 32'h1);

    // Fall-through behaviour.
    cyc(1, 8'h5A, 0, 0, 1);
    chk("fwft_first", 32'(dout_f), 32'h5A);
    cyc(1, 8'h5B, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    chk("fwft_next", 32'(dout_f), 32'h5B);
    cyc(0, 8'h00, 1, 0, 0);
    chk("fwft_empty", 32'(dout_f), 32'h00);

    // Flush with concurrent write, after an overflow.
    for (int i = 0; i < 9; i++) cyc(1, 8'(8'h60 + i), 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0, 0);
    cyc(1, 8'h77, 0, 1, 0);
    chk("flush_ovf", 32'(ovf_s), 32'h1);
    cyc(0, 8'h00, 1, 1, 0);
    chk("flush_no_unf", 32'(unf_s), 32'h0);

    // Randomised traffic with phase-dependent bias.
    for (int i = 0; i < 2000; i++) begin
      int wp, rp;
      case ((i / 100) % 4)
        0:       begin wp = 80; rp = 30; end
        1:       begin wp = 30; rp = 80; end
        2:       begin wp = 95; rp = 5;  end
        default: begin wp = 50; rp = 50; end
      endcase
      cyc($urandom_range(99) < wp,
          8'($urandom),
          $urandom_range(99) < rp,
          $urandom_range(63) == 0,
          $urandom_range(31) == 0);
    end

    // Asynchronous reset mid-fill.
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h90 + i), 0, 0, 0);
    cyc(1, 8'hEE, 1, 0, 0);
    wen = 0; ren = 0; flush = 0; clr_err = 0;
    #3 reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    cyc(1, 8'hC3, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    chk("post_reset", 32'(dout_s), 32'hC3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
